// File: rtl/pic_arbiter.sv
// pic_arbiter: programmable interrupt controller front end.
// Rising edges on irq_in are latched into pending bits. The highest-priority
// enabled pending source is presented to the vector sequencer as
// {valid, priority, vector}. A CPU request is raised while the presented
// priority outranks the current CPU priority. The serviced source's pending
// bit is cleared on the sequencer's acknowledge.
module pic_arbiter #(
  parameter int NUM_SRC = 8,
  parameter int PRI_W   = 3,
  parameter int VEC_W   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRC-1:0]           irq_in,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_SRC)-1:0]   cfg_idx,
  input  logic [PRI_W+VEC_W:0]         cfg_data,
  input  logic [PRI_W-1:0]             curr_pri,
  input  logic                         iv_busy,
  input  logic                         pic_ack,
  output logic [PRI_W+VEC_W:0]         pic_out,
  output logic                         irq_req,
  output logic [NUM_SRC-1:0]           pend_out
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int OUT_W = 1 + PRI_W + VEC_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_PRESENT,
    ST_CLEAR
  } state_t;

  state_t              state_q;
  logic [OUT_W-1:0]    pic_out_q;
  logic [IDX_W-1:0]    gidx_q;

  // Input sample register and pending bits
  logic [NUM_SRC-1:0]  irq_in_q;
  logic [NUM_SRC-1:0]  pend_q;
  logic [NUM_SRC-1:0]  pend_d;
  logic [NUM_SRC-1:0]  rise;
  logic [NUM_SRC-1:0]  clr;

  // Per-source configuration
  logic [NUM_SRC-1:0]  cfg_en_q;
  logic [PRI_W-1:0]    cfg_pri_q [NUM_SRC];
  logic [VEC_W-1:0]    cfg_vec_q [NUM_SRC];
  logic [NUM_SRC-1:0]  cfg_hit;

  // Arbitration results
  logic [NUM_SRC-1:0]  eligible;
  logic                win_valid;
  logic [IDX_W-1:0]    win_idx;
  logic [PRI_W-1:0]    win_pri;
  logic [VEC_W-1:0]    win_vec;

  logic [PRI_W-1:0]    pres_pri;
  logic                pres_ok;

  genvar gi;

  // Per-source edge detect, pending next-state and config write decode.
  // A rising edge on the same cycle as the clear wins so no interrupt is lost.
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign rise[gi]    = irq_in[gi] & ~irq_in_q[gi];
      assign clr[gi]     = (state_q == ST_CLEAR) && (gidx_q == IDX_W'(gi));
      assign pend_d[gi]  = rise[gi] | (pend_q[gi] & ~clr[gi]);
      assign cfg_hit[gi] = cfg_we && (cfg_idx == IDX_W'(gi));
    end
  endgenerate

  assign eligible = cfg_en_q & pend_q;

  // Sample the interrupt lines and update the pending bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_in_q <= '0;
      pend_q   <= '0;
    end else begin
      irq_in_q <= irq_in;
      pend_q   <= pend_d;
    end
  end

  // Configuration registers, one record per source
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_en_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        cfg_pri_q[i] <= '0;
        cfg_vec_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (cfg_hit[i]) begin
          cfg_en_q[i]  <= cfg_data[OUT_W-1];
          cfg_pri_q[i] <= cfg_data[OUT_W-2 -: PRI_W];
          cfg_vec_q[i] <= cfg_data[VEC_W-1:0];
        end
      end
    end
  end

  // Priority arbitration: highest value wins, strict compare keeps the lowest index on ties
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    win_pri   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && (!win_valid || (cfg_pri_q[i] > win_pri))) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'(i);
        win_pri   = cfg_pri_q[i];
      end
    end
  end

  assign win_vec  = cfg_vec_q[win_idx];

  // The presented source is still worth presenting only while enabled and pending
  assign pres_pri = pic_out_q[OUT_W-2 -: PRI_W];
  assign pres_ok  = cfg_en_q[gidx_q] & pend_q[gidx_q];

  // Presentation sequencer: IDLE -> SCAN -> PRESENT -> CLEAR -> IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pic_out_q <= '0;
      gidx_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_valid && !iv_busy) begin
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // The winner can vanish between IDLE and SCAN if it is disabled meanwhile
          if (win_valid) begin
            gidx_q    <= win_idx;
            pic_out_q <= {1'b1, win_pri, win_vec};
            state_q   <= ST_PRESENT;
          end else begin
            pic_out_q <= '0;
            state_q   <= ST_IDLE;
          end
        end
        ST_PRESENT: begin
          if (pic_ack) begin
            state_q <= ST_CLEAR;
          end else if (!pres_ok) begin
            pic_out_q <= '0;
            state_q   <= ST_IDLE;
          end else if (!iv_busy && win_valid && (win_pri > pres_pri)) begin
            state_q <= ST_SCAN;
          end
        end
        ST_CLEAR: begin
          pic_out_q <= '0;
          state_q   <= ST_IDLE;
        end
        default: begin
          pic_out_q <= '0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign pic_out  = pic_out_q;
  assign pend_out = pend_q;
  // Equal priority keeps pic_out valid for chaining but does not interrupt the CPU
  assign irq_req  = (state_q == ST_PRESENT) && (pres_pri > curr_pri);

endmodule

// File: tb/tb_pic_arbiter.sv
// tb_pic_arbiter: directed table-driven checks plus hand-written multi-cycle sequences.
module tb_pic_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in;
  logic       cfg_we;
  logic [2:0] cfg_idx;
  logic [7:0] cfg_data;
  logic [2:0] curr_pri;
  logic       iv_busy;
  logic       pic_ack;
  logic [7:0] pic_out;
  logic       irq_req;
  logic [7:0] pend_out;

  int n_vec = 0;
  int n_err = 0;

  pic_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .irq_in   (irq_in),
    .cfg_we   (cfg_we),
    .cfg_idx  (cfg_idx),
    .cfg_data (cfg_data),
    .curr_pri (curr_pri),
    .iv_busy  (iv_busy),
    .pic_ack  (pic_ack),
    .pic_out  (pic_out),
    .irq_req  (irq_req),
    .pend_out (pend_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] idx;
    logic [7:0] cfg;
    logic [2:0] cpri;
    logic [7:0] exp_pic;
    logic       exp_req;
    logic [7:0] exp_pend_after;
  } vec_t;

  vec_t tbl [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end else begin
      $display("ok   %s: %02h", name, act);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [7:0] data);
    cfg_we   = 1'b1;
    cfg_idx  = idx;
    cfg_data = data;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic ack_pulse();
    pic_ack = 1'b1;
    tick();
    pic_ack = 1'b0;
  endtask

  initial begin
    logic [7:0] one_hot;

    // {idx, cfg, curr_pri, pic_out, irq_req, pend after ack}
    tbl[0] = '{3'd2, 8'hD3, 3'd2, 8'hD3, 1'b1, 8'h00}; // en, pri5, vec3
    tbl[1] = '{3'd0, 8'hB0, 3'd3, 8'hB0, 1'b0, 8'h00}; // equal priority: no request
    tbl[2] = '{3'd7, 8'hFF, 3'd6, 8'hFF, 1'b1, 8'h00}; // max pri and vector
    tbl[3] = '{3'd5, 8'h5A, 3'd0, 8'h00, 1'b0, 8'h20}; // disabled: masked, ack ignored
    tbl[4] = '{3'd3, 8'h8C, 3'd0, 8'h8C, 1'b0, 8'h00}; // pri 0 never outranks
    tbl[5] = '{3'd6, 8'hE9, 3'd5, 8'hE9, 1'b1, 8'h00}; // pri6 over curr 5

    rst = 1'b1; irq_in = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0;
    curr_pri = '0; iv_busy = 1'b0; pic_ack = 1'b0;
    #1;
    chk("rst_pic_out", pic_out, 8'h00);
    chk("rst_pend", pend_out, 8'h00);
    chk("rst_irq_req", {7'd0, irq_req}, 8'h00);
    tick();
    rst = 1'b0;
    tick();

    // Single-source presentation vectors
    for (int i = 0; i < 6; i++) begin
      do_reset();
      cfg_write(tbl[i].idx, tbl[i].cfg);
      curr_pri = tbl[i].cpri;
      one_hot  = 8'h01 << tbl[i].idx;
      irq_in   = one_hot;
      tick();
      chk($sformatf("v%0d_pend", i), pend_out, one_hot);
      irq_in = '0;
      tick();
      tick();
      chk($sformatf("v%0d_pic", i), pic_out, tbl[i].exp_pic);
      chk($sformatf("v%0d_req", i), {7'd0, irq_req}, {7'd0, tbl[i].exp_req});
      ack_pulse();
      tick();
      chk($sformatf("v%0d_pend_ack", i), pend_out, tbl[i].exp_pend_after);
      chk($sformatf("v%0d_pic_ack", i), pic_out, 8'h00);
    end

    // Priority and tie-break ordering: src1, src6 (pri4) then src3 (pri2)
    do_reset();
    cfg_write(3'd1, 8'hC1);
    cfg_write(3'd6, 8'hC6);
    cfg_write(3'd3, 8'hA3);
    curr_pri = 3'd0;
    irq_in = 8'b0100_1010;
    tick();
    irq_in = '0;
    tick();
    tick();
    chk("tie_first", pic_out, 8'hC1);
    ack_pulse(); tick(); tick(); tick();
    chk("tie_second", pic_out, 8'hC6);
    ack_pulse(); tick(); tick(); tick();
    chk("tie_third", pic_out, 8'hA3);
    ack_pulse(); tick();
    chk("tie_pend_empty", pend_out, 8'h00);

    // Equal CPU priority, then lowering it raises the request combinationally
    do_reset();
    cfg_write(3'd0, 8'hB0);
    curr_pri = 3'd3;
    irq_in = 8'h01;
    tick();
    irq_in = '0;
    tick();
    tick();
    chk("eq_pri_pic", pic_out, 8'hB0);
    chk("eq_pri_req", {7'd0, irq_req}, 8'h00);
    curr_pri = 3'd1;
    #1;
    chk("lower_cpri_req", {7'd0, irq_req}, 8'h01);

    // Re-arbitration on a higher-priority arrival, and its suppression while busy
    do_reset();
    curr_pri = 3'd0;
    cfg_write(3'd0, 8'hB0);
    cfg_write(3'd7, 8'hE7);
    irq_in = 8'h01;
    tick();
    irq_in = '0;
    tick();
    tick();
    chk("pre_src0", pic_out, 8'hB0);
    irq_in = 8'h80;
    tick();
    irq_in = '0;
    tick();
    tick();
    chk("rearb_src7", pic_out, 8'hE7);
    ack_pulse(); tick(); tick(); tick();
    chk("back_src0", pic_out, 8'hB0);
    iv_busy = 1'b1;
    irq_in = 8'h80;
    tick();
    irq_in = '0;
    tick(); tick(); tick();
    chk("busy_hold_pic", pic_out, 8'hB0);
    chk("busy_hold_pend", pend_out, 8'h81);
    ack_pulse(); tick();
    chk("busy_ack_pic", pic_out, 8'h00);
    chk("busy_ack_pend", pend_out, 8'h80);
    tick(); tick();
    chk("busy_idle_pic", pic_out, 8'h00);
    iv_busy = 1'b0;
    tick(); tick();
    chk("unbusy_src7", pic_out, 8'hE7);

    // Disabling the presented source withdraws it but keeps it pending
    do_reset();
    curr_pri = 3'd0;
    cfg_write(3'd4, 8'hD4);
    irq_in = 8'h10;
    tick();
    irq_in = '0;
    tick();
    tick();
    chk("src4_pic", pic_out, 8'hD4);
    cfg_write(3'd4, 8'h54);
    tick();
    chk("disable_pic", pic_out, 8'h00);
    chk("disable_pend", pend_out, 8'h10);
    cfg_write(3'd4, 8'hD4);
    tick(); tick();
    chk("reenable_pic", pic_out, 8'hD4);

    // Edge coinciding with clear, held level, then async reset while presenting
    do_reset();
    curr_pri = 3'd0;
    cfg_write(3'd5, 8'hA5);
    irq_in = 8'h20;
    tick();
    irq_in = '0;
    tick();
    tick();
    chk("src5_pic", pic_out, 8'hA5);
    ack_pulse();
    irq_in = 8'h20;
    tick();
    chk("set_wins_pend", pend_out, 8'h20);
    chk("set_wins_pic", pic_out, 8'h00);
    tick(); tick();
    chk("re_present", pic_out, 8'hA5);
    ack_pulse(); tick();
    chk("held_level_pend", pend_out, 8'h00);
    tick(); tick();
    chk("held_level_pend2", pend_out, 8'h00);
    chk("held_level_pic", pic_out, 8'h00);
    irq_in = '0;
    tick();
    irq_in = 8'h20;
    tick();
    irq_in = '0;
    tick(); tick();
    chk("pre_rst_req", {7'd0, irq_req}, 8'h01);
    rst = 1'b1;
    #1;
    chk("async_rst_pic", pic_out, 8'h00);
    chk("async_rst_pend", pend_out, 8'h00);
    chk("async_rst_req", {7'd0, irq_req}, 8'h00);
    tick();
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pic_arbiter.md
Name: pic_arbiter

Overview:
- Programmable interrupt controller that arbitrates among device interrupt lines.
- Latches edges into pending bits, selects the highest-priority enabled pending source, and presents it to the interrupt vector sequencer as an 8-bit status byte: bit7 valid, [6:4] priority, [3:0] vector.
- Raises a request to the CPU when the winner outranks the current CPU priority.
- Clears the serviced source on the sequencer's acknowledge.

Parameters:
- NUM_SRC, 8, number of interrupt sources (index width 3).
- PRI_W, 3, priority field width.
- VEC_W, 4, vector number width.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- irq_in  input  8  device interrupt lines, level; rising edge sets pending.
- cfg_we  input  1  configuration write strobe.
- cfg_idx  input  3  source index being configured.
- cfg_data  input  8  bit7 enable, [6:4] priority, [3:0] vector.
- curr_pri  input  3  current CPU priority from PSW.
- iv_busy  input  1  vector entry/return sequence in progress.
- pic_ack  input  1  one-cycle pulse; sequencer has accepted the presented vector.
- pic_out  output  8  {valid, priority[2:0], vector[3:0]} to sequencer.
- irq_req  output  1  request to CPU to start vector entry.
- pend_out  output  8  current pending bits, for debug and status.

Behaviour:
- Reset (async, immediate):
  - pending = 0; all config = 0 (disabled, pri 0, vec 0).
  - irq_in sample register = 0; pic_out = 8'h00; state = IDLE; irq_req = 0.
- Edge detect:
  - pending[i] sets on the cycle after irq_in[i] is sampled 1 while its previous sample was 0.
  - A level held high sets pending only once.
- Config write: cfg_we with cfg_idx and cfg_data updates that source's config at the clock edge.
  - Disabled sources keep their pending bit but are masked from arbitration.
- Arbitration (combinational over enabled & pending):
  - Highest priority value wins.
  - Ties go to the lowest index.
  - winner_valid = 0 when no source is eligible.
- State machine:
  - IDLE: if winner_valid and !iv_busy -> SCAN.
  - SCAN: register winner index, priority and vector into pic_out with bit7 = 1 -> PRESENT.
  - PRESENT: pic_out held stable. Checks in priority order:
    1. pic_ack -> CLEAR.
    2. Presented source disabled or its pending bit clear -> IDLE, with pic_out = 0 on the next edge.
    3. !iv_busy and an eligible source with strictly higher priority than pic_out[6:4] -> SCAN (re-arbitrate).
  - CLEAR: clear pending of the granted index; pic_out = 0 -> IDLE.
    - If an irq_in rising edge on the same index coincides with the clear, set wins and pending stays 1.
- irq_req: combinational; 1 iff state == PRESENT and pic_out[6:4] > curr_pri.
  - When curr_pri equals the presented priority, pic_out stays valid but irq_req = 0. The sequencer's return path uses pic_out for chaining.
- pic_ack is ignored in any state other than PRESENT.
- Latency:
  - irq_in edge at cycle N -> pending at N+1.
  - SCAN at N+2 (if IDLE and !iv_busy).
  - pic_out valid and irq_req at N+3.
- Mid-sequence: while iv_busy = 1, no new presentation from IDLE and no re-arbitration in PRESENT; an ack during busy is honoured.
- Reset asserted in any state returns everything to its reset values immediately; pending edges are lost.

Test Plan:
- Reset, then configure src2 = {en, pri 5, vec 3}, curr_pri = 2; pulse irq_in[2] at cycle N.
  -> pend_out = 8'h04 at N+1; pic_out = 8'hD3 and irq_req = 1 at N+3; pic_ack pulse -> pend_out = 0 and pic_out = 0 two cycles later.
- src1 = pri 4, src6 = pri 4, src3 = pri 2; all raised in the same cycle.
  -> pic_out presents src1; after ack, src6; after ack, src3.
- src0 = pri 3 presented; curr_pri = 3.
  -> pic_out = 8'hB0 with irq_req = 0. Setting curr_pri = 1 -> irq_req = 1 the same cycle.
- src0 = pri 3 presented, iv_busy = 0; src7 = pri 6 raised.
  -> pic_out switches to src7 via SCAN. Repeat with iv_busy = 1 -> pic_out stays src0.
- Presented src4 disabled via cfg write.
  -> pic_out = 0 next cycle; pend_out[4] remains 1; re-enable -> presented again.
- irq_in[5] re-rises in the CLEAR cycle of src5.
  -> pend_out[5] stays 1 and src5 is re-presented. Assert rst while in PRESENT -> pic_out = 0, pend_out = 0, irq_req = 0 without waiting for a clock edge.
